alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one `alu` instance between two requesters, e.g. the execute stage and the RSA modular-arithmetic sequencer. The arbiter accepts one operation at a time over a valid/ready handshake. It latches the operands, drives the shared ALU for one cycle, registers the result and flags, and returns them to the winning requester over a response handshake. It sits beside the `alu` in the execute cluster, and its `alu_*` ports connect directly to that ALU.

Parameters:
N, 4, operand/result width; must match the `alu` instance's N.

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  reset; synchronous, active-low.
req_valid_i  in  2  per-requester operation valid; bit k = requester k.
req_ready_o  out  2  per-requester accept; at most one bit high.
a0_i, b0_i  in  N each  requester 0 operands.
op0_i  in  3  requester 0 opcode (alu_defs encoding).
a1_i, b1_i  in  N each  requester 1 operands.
op1_i  in  3  requester 1 opcode.
rsp_valid_o  out  2  per-requester response valid; at most one bit high.
rsp_ready_i  in  2  per-requester response accept.
rsp_result_o  out  N  registered ALU result (shared bus; qualify with rsp_valid_o).
rsp_flags_o  out  2  registered ALUFlags: [0]=zero, [1]=negative.
alu_a_o, alu_b_o  out  N each  operands to the shared ALU.
alu_opcode_o  out  3  opcode to the shared ALU.
alu_result_i  in  N  ALU result_o.
alu_flags_i  in  2  ALU ALUFlags.
busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - State goes to IDLE.
  - Operand and opcode latches, rsp_result_o and rsp_flags_o clear to 0.
  - rsp_valid_o=2'b00, busy_o=0.
  - Priority pointer prio is set to requester 0.
- A reset in any state, including mid-operation, abandons the operation; no response is ever issued for it.
- State machine IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner selection: if only one req_valid_i bit is set, that requester wins; if both are set, requester prio wins.
  - req_ready_o is combinational: only the winner's bit is high, and only in IDLE.
  - The handshake fires in the same cycle. On that clock edge: latch a/b/op, record the winner id, go to EXEC.
  - No valid: stay in IDLE, req_ready_o=0.
- EXEC:
  - alu_a_o, alu_b_o and alu_opcode_o come from the latches and are stable for the whole cycle.
  - At the clock edge: rsp_result_o<=alu_result_i, rsp_flags_o<=alu_flags_i, go to RESP.
- RESP:
  - rsp_valid_o[winner]=1; result and flags are held stable.
  - When rsp_ready_i[winner]=1: go to IDLE, set prio to the other requester, deassert rsp_valid_o on the next cycle.
  - rsp_ready_i of the non-winner is ignored.
  - The pending request of the other requester is not accepted until IDLE.
- Latency:
  - Accept at edge T; rsp_valid_o is high from cycle T+2.
  - Minimum issue interval is 3 cycles when the response is accepted immediately.
- alu_* outputs always reflect the latches, including in IDLE and RESP (last operation, or 0 after reset). This gives no spurious toggling.
- Requesters hold valid, operands and opcode stable until ready; changes while ready is low are allowed and are not captured.
- The opcode is passed through unmodified; the arbiter does no arithmetic and no width conversion.
- Fairness: with both requesters valid continuously, grants strictly alternate 0,1,0,1. Neither requester is starved beyond one operation.
- The winner's id is visible only through rsp_valid_o; rsp_result_o is shared.

Test Plan:
1. Reset, then only req_valid_i=2'b01 with a0=4'b1100, b0=4'b1010, op0=AND_; response ready held high.
   - req_ready_o=2'b01 in that cycle.
   - rsp_valid_o=2'b01 two cycles later.
   - rsp_result_o=4'b1000, rsp_flags_o=2'b10.
2. Requester 1 alone, a1=4'b0101, b1=4'b0101, op1=AND_ to force a zero-flag case (4'b0101 AND 4'b0101 is 4'b0101, not zero, so use b1=4'b1010 instead).
   - Result 4'b0000, flags 2'b01.
   - rsp_valid_o=2'b10.
3. Both valid continuously for 4 operations after reset.
   - Grant order 0,1,0,1.
   - req_ready_o never equals 2'b11.
4. rsp_ready_i held low for 5 cycles in RSP.
   - rsp_valid_o and result stay stable.
   - The other requester's req_ready_o stays 0.
   - busy_o=1 throughout.
5. rsp_ready_i asserted only for the non-winner.
   - Response is not consumed; state remains RESP.
6. rst_n_i driven low during EXEC.
   - Next cycle: rsp_valid_o=0, busy_o=0, outputs 0.
   - The abandoned operation never produces a response; prio is reset to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters
module alu_share_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [N-1:0] a0_i,
  input  logic [N-1:0] b0_i,
  input  logic [2:0]   op0_i,
  input  logic [N-1:0] a1_i,
  input  logic [N-1:0] b1_i,
  input  logic [2:0]   op1_i,
  output logic [1:0]   rsp_valid_o,
  input  logic [1:0]   rsp_ready_i,
  output logic [N-1:0] rsp_result_o,
  output logic [1:0]   rsp_flags_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [2:0]   alu_opcode_o,
  input  logic [N-1:0] alu_result_i,
  input  logic [1:0]   alu_flags_i,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [N-1:0] a_q, b_q;
  logic [2:0] op_q;
  logic win_q, prio_q, win, grant, done;
  always_comb begin
    win = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];
    grant = (state == IDLE) && |req_valid_i;
    done = (state == RESP) && rsp_ready_i[win_q];
    req_ready_o = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid_o = (state == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    busy_o = state != IDLE;
    alu_a_o = a_q;
    alu_b_o = b_q;
    alu_opcode_o = op_q;
    state_n = state;
    if (grant) state_n = EXEC;
    if (state == EXEC) state_n = RESP;
    if (done) state_n = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      win_q <= 1'b0;
      prio_q <= 1'b0;
      rsp_result_o <= '0;
      rsp_flags_o <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        a_q <= win ? a1_i : a0_i;
        b_q <= win ? b1_i : b0_i;
        op_q <= win ? op1_i : op0_i;
        win_q <= win;
      end
      if (state == EXEC) begin
        rsp_result_o <= alu_result_i;
        rsp_flags_o <= alu_flags_i;
      end
      if (done) prio_q <= ~win_q;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, handshakes and reset
module tb_alu_share_arbiter;
  localparam int N = 4;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_flags, alu_flags;
  logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, rsp_result, alu_a, alu_b, alu_result;
  logic [2:0] op0 = '0, op1 = '0, alu_op;
  logic busy;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  always_comb begin
    alu_result = (alu_op == ADD) ? alu_a + alu_b :
                 (alu_op == SUB) ? alu_a - alu_b :
                 (alu_op == AND_) ? alu_a & alu_b :
                 (alu_op == OR_) ? alu_a | alu_b : alu_a ^ alu_b;
    alu_flags = {alu_result[N-1], alu_result == '0};
  end
  alu_share_arbiter #(.N(N)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .a0_i(a0), .b0_i(b0), .op0_i(op0), .a1_i(a1), .b1_i(b1), .op1_i(op1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_flags_o(rsp_flags), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_op),
    .alu_result_i(alu_result), .alu_flags_i(alu_flags), .busy_o(busy)
  );
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if ({rsp_valid, busy, req_ready, rsp_result, rsp_flags, alu_a, alu_b, alu_op} !== '0)
      $display("FAIL reset: got valid=%b busy=%b ready=%b res=%b fl=%b a=%b b=%b op=%b want all 0",
               rsp_valid, busy, req_ready, rsp_result, rsp_flags, alu_a, alu_b, alu_op);
    else pass_cnt++;
  endtask
  task automatic test_req0_alone();
    rsp_ready = 2'b11;
    a0 = 4'b1100; b0 = 4'b1010; op0 = AND_;
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL r0_ready: got %b want 01", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b00;
    total++;
    if (busy !== 1'b1 || rsp_valid !== 2'b00 || alu_a !== 4'b1100 || alu_b !== 4'b1010 || alu_op !== AND_)
      $display("FAIL r0_exec: got busy=%b valid=%b a=%b b=%b op=%0d want 1 00 1100 1010 %0d",
               busy, rsp_valid, alu_a, alu_b, alu_op, AND_);
    else pass_cnt++;
    step();
    total++;
    if (rsp_valid !== 2'b01 || rsp_result !== 4'b1000 || rsp_flags !== 2'b10)
      $display("FAIL r0_resp: got valid=%b res=%b fl=%b want 01 1000 10", rsp_valid, rsp_result, rsp_flags);
    else pass_cnt++;
    step();
    total++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || alu_a !== 4'b1100)
      $display("FAIL r0_idle: got valid=%b busy=%b a=%b want 00 0 1100", rsp_valid, busy, alu_a);
    else pass_cnt++;
  endtask
  task automatic test_req1_zero();
    a1 = 4'b0101; b1 = 4'b1010; op1 = AND_;
    req_valid = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) $display("FAIL r1_ready: got %b want 10", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b00;
    step();
    total++;
    if (rsp_valid !== 2'b10 || rsp_result !== 4'b0000 || rsp_flags !== 2'b01)
      $display("FAIL r1_resp: got valid=%b res=%b fl=%b want 10 0000 01", rsp_valid, rsp_result, rsp_flags);
    else pass_cnt++;
    step();
  endtask
  task automatic test_fairness();
    logic [1:0] exp_ready;
    logic [N-1:0] exp_res;
    logic [1:0] exp_fl;
    do_reset();
    step();
    rsp_ready = 2'b11;
    a0 = 4'b0011; b0 = 4'b0101; op0 = ADD;
    a1 = 4'b0111; b1 = 4'b0111; op1 = SUB;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_ready = k[0] ? 2'b10 : 2'b01;
      exp_res = k[0] ? 4'b0000 : 4'b1000;
      exp_fl = k[0] ? 2'b01 : 2'b10;
      #1;
      total++;
      if (req_ready !== exp_ready) $display("FAIL grant%0d: got %b want %b", k, req_ready, exp_ready);
      else pass_cnt++;
      step();
      total++;
      if (req_ready === 2'b11) $display("FAIL ready_exec%0d: got 11 want 00", k); else pass_cnt++;
      step();
      total++;
      if (rsp_valid !== exp_ready || rsp_result !== exp_res || rsp_flags !== exp_fl || req_ready !== 2'b00)
        $display("FAIL fair_resp%0d: got valid=%b res=%b fl=%b ready=%b want %b %b %b 00",
                 k, rsp_valid, rsp_result, rsp_flags, req_ready, exp_ready, exp_res, exp_fl);
      else pass_cnt++;
      step();
    end
    req_valid = 2'b00;
  endtask
  task automatic test_stall_and_nonwinner();
    rsp_ready = 2'b00;
    a0 = 4'b1001; b0 = 4'b0100; op0 = OR_;
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL stall_grant: got %b want 01", req_ready); else pass_cnt++;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rsp_valid !== 2'b01 || rsp_result !== 4'b1101 || rsp_flags !== 2'b10 || req_ready !== 2'b00 || busy !== 1'b1)
        $display("FAIL stall%0d: got valid=%b res=%b fl=%b ready=%b busy=%b want 01 1101 10 00 1",
                 k, rsp_valid, rsp_result, rsp_flags, req_ready, busy);
      else pass_cnt++;
      step();
    end
    rsp_ready = 2'b10;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (rsp_valid !== 2'b01 || busy !== 1'b1 || req_ready !== 2'b00)
        $display("FAIL nonwinner%0d: got valid=%b busy=%b ready=%b want 01 1 00", k, rsp_valid, busy, req_ready);
      else pass_cnt++;
    end
    rsp_ready = 2'b01;
    step();
    total++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b10)
      $display("FAIL release: got valid=%b ready=%b want 00 10", rsp_valid, req_ready);
    else pass_cnt++;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
  endtask
  task automatic test_reset_mid_op();
    do_reset();
    step();
    rsp_ready = 2'b11;
    a0 = 4'b0001; b0 = 4'b0001; op0 = ADD;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    step();
    a0 = 4'b0110; b0 = 4'b0011; op0 = SUB;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if ({rsp_valid, busy, rsp_result, rsp_flags, alu_a, alu_b, alu_op} !== '0)
      $display("FAIL midreset: got valid=%b busy=%b res=%b fl=%b a=%b b=%b op=%b want all 0",
               rsp_valid, busy, rsp_result, rsp_flags, alu_a, alu_b, alu_op);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0)
        $display("FAIL abandoned%0d: got valid=%b busy=%b want 00 0", k, rsp_valid, busy);
      else pass_cnt++;
    end
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL prio_reset: got %b want 01", req_ready); else pass_cnt++;
    req_valid = 2'b00;
    step();
  endtask
  initial begin
    test_reset();
    test_req0_alone();
    test_req1_zero();
    test_fairness();
    test_stall_and_nonwinner();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
